// File: rtl/e_mdu_pkg.sv
// e_mdu shared definitions
// opcode encoding, default latencies, start decode helper
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } mdop_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu E-stage bundle
// operands/opcode in, HI/LO read and busy/start out
interface e_mdu_if;

    logic [3:0]  E_mdop;
    logic [31:0] E_V1;
    logic [31:0] E_V2;
    logic [31:0] E_HILO;
    logic        E_start;
    logic        E_busy;

    modport master (
        output E_mdop, E_V1, E_V2,
        input  E_HILO, E_start, E_busy
    );

    modport slave (
        input  E_mdop, E_V1, E_V2,
        output E_HILO, E_start, E_busy
    );

endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit
// fixed-latency mult/div owning HI/LO
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave md
);

    localparam int MAX_LAT =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   hi;
    logic [31:0]   lo;

    logic          busy;
    logic          start;
    logic          is_mul;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          sgn;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_we;

    assign busy   = (cnt != '0);
    assign start  = is_md_start(md.E_mdop) && !busy;
    assign is_mul = (md.E_mdop == MD_MULT) ||
                    (md.E_mdop == MD_MULTU);

    assign md.E_busy  = busy;
    assign md.E_start = start;

    // HI/LO read port, independent of busy
    always_comb begin
        md.E_HILO = '0;
        unique case (1'b1)
            (md.E_mdop == MD_MFHI): md.E_HILO = hi;
            (md.E_mdop == MD_MFLO): md.E_HILO = lo;
            default: md.E_HILO = '0;
        endcase
    end

    // result from latched operands; signed divide via magnitudes
    // so 0x80000000 / -1 never overflows
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        res_we = 1'b0;
        prod_s = $signed({{32{a_q[31]}}, a_q}) *
                 $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        sgn    = (op_q == MD_DIV);
        a_neg  = sgn && a_q[31];
        b_neg  = sgn && b_q[31];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        q_mag  = (b_mag != '0) ? a_mag / b_mag : '0;
        r_mag  = (b_mag != '0) ? a_mag % b_mag : '0;
        unique case (1'b1)
            (op_q == MD_MULT): begin
                {res_hi, res_lo} = prod_s;
                res_we = 1'b1;
            end
            (op_q == MD_MULTU): begin
                {res_hi, res_lo} = prod_u;
                res_we = 1'b1;
            end
            (op_q == MD_DIV): begin
                res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
                res_hi = a_neg ? -r_mag : r_mag;
                res_we = (b_q != '0);
            end
            (op_q == MD_DIVU): begin
                res_lo = q_mag;
                res_hi = r_mag;
                res_we = (b_q != '0);
            end
            default: res_we = 1'b0;
        endcase
    end

    // start latches operands; counter runs down, commit on last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (start) begin
            a_q  <= md.E_V1;
            b_q  <= md.E_V2;
            op_q <= md.E_mdop;
            cnt  <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (md.E_mdop == MD_MTHI) begin
            hi <= md.E_V1;
        end else if (md.E_mdop == MD_MTLO) begin
            lo <= md.E_V1;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu
// reference model predicts per-cycle outputs; monitor compares
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int NM = MD_MULT_CYCLES;
    localparam int ND = MD_DIV_CYCLES;

    typedef struct {
        logic [31:0] hilo;
        logic        start;
        logic        busy;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    e_mdu_if bus();

    e_mdu dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // reference model state
    int          cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          busy_end = 0;
    logic        p_valid = 1'b0;
    int          p_cyc = 0;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    function automatic logic m_busy();
        return cyc < busy_end;
    endfunction

    // monitor: compare DUT outputs against the queued prediction
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (bus.E_HILO !== e.hilo) begin
                fails++;
                $display("FAIL hilo cyc=%0d got=%h want=%h",
                         e.cyc, bus.E_HILO, e.hilo);
            end
            tests++;
            if (bus.E_start !== e.start) begin
                fails++;
                $display("FAIL start cyc=%0d got=%b want=%b",
                         e.cyc, bus.E_start, e.start);
            end
            tests++;
            if (bus.E_busy !== e.busy) begin
                fails++;
                $display("FAIL busy cyc=%0d got=%b want=%b",
                         e.cyc, bus.E_busy, e.busy);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] op,
                        input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        logic bsy;
        logic st;
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        logic [63:0] pr;
        @(posedge clk);
        #1;
        reset = r;
        bus.E_mdop = op;
        bus.E_V1 = v1;
        bus.E_V2 = v2;
        bsy = m_busy();
        st = is_md_start(op) && !bsy;
        e.hilo = (op == MD_MFHI) ? m_hi :
                 (op == MD_MFLO) ? m_lo : 32'd0;
        e.start = st;
        e.busy = bsy;
        e.cyc = cyc;
        exp_q.push_back(e);
        if (r) begin
            m_hi = '0;
            m_lo = '0;
            busy_end = 0;
            p_valid = 1'b0;
        end else begin
            if (p_valid && cyc == p_cyc) begin
                m_hi = p_hi;
                m_lo = p_lo;
                p_valid = 1'b0;
            end
            if (st) begin
                sa = longint'($signed(v1));
                sb = longint'($signed(v2));
                p_valid = 1'b1;
                if (op == MD_MULT) begin
                    pr = 64'(sa * sb);
                    {p_hi, p_lo} = pr;
                end else if (op == MD_MULTU) begin
                    pr = {32'd0, v1} * {32'd0, v2};
                    {p_hi, p_lo} = pr;
                end else if (v2 == 0) begin
                    p_valid = 1'b0;
                end else if (op == MD_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p_lo = sq[31:0];
                    p_hi = sr[31:0];
                end else begin
                    p_lo = v1 / v2;
                    p_hi = v1 % v2;
                end
                if (op == MD_MULT || op == MD_MULTU) begin
                    p_cyc = cyc + NM;
                    busy_end = cyc + NM + 1;
                end else begin
                    p_cyc = cyc + ND;
                    busy_end = cyc + ND + 1;
                end
            end else if (!bsy && op == MD_MTHI) begin
                m_hi = v1;
            end else if (!bsy && op == MD_MTLO) begin
                m_lo = v1;
            end
        end
        cyc++;
    endtask

    task automatic idle_free();
        while (m_busy()) step(1'b0, MD_NONE, '0, '0);
    endtask

    task automatic op_then_read(input logic [3:0] op,
                                input logic [31:0] v1,
                                input logic [31:0] v2);
        step(1'b0, op, v1, v2);
        idle_free();
        step(1'b0, MD_MFHI, '0, '0);
        step(1'b0, MD_MFLO, '0, '0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        reset = 1'b1;
        bus.E_mdop = MD_NONE;
        bus.E_V1 = '0;
        bus.E_V2 = '0;
        repeat (2) @(posedge clk);

        // reset state and start under reset
        step(1'b1, MD_MFLO, '0, '0);
        step(1'b1, MD_MFHI, '0, '0);
        step(1'b1, MD_MULT, 32'd9, 32'd9);
        step(1'b0, MD_MFLO, '0, '0);

        // directed arithmetic
        op_then_read(MD_MULT,  32'hFFFF_FFFE, 32'd3);
        op_then_read(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        op_then_read(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        op_then_read(MD_DIVU,  32'd7, 32'd0);
        op_then_read(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

        // moves, and moves/starts ignored while busy
        step(1'b0, MD_MTHI, 32'h1234_5678, '0);
        step(1'b0, MD_MFHI, '0, '0);
        step(1'b0, MD_MULT, 32'd6, 32'd7);
        step(1'b0, MD_MTLO, 32'hDEAD_BEEF, '0);
        step(1'b0, MD_DIV, 32'd100, 32'd3);
        step(1'b0, MD_MFLO, '0, '0);
        idle_free();
        step(1'b0, MD_MFLO, '0, '0);

        // back-to-back starts with no dead cycle
        step(1'b0, MD_MULTU, 32'd5, 32'd5);
        idle_free();
        step(1'b0, MD_DIVU, 32'd50, 32'd7);
        idle_free();
        step(1'b0, MD_MFHI, '0, '0);

        // reset in the middle of a divide, then a clean multiply
        step(1'b0, MD_DIV, 32'd1000, 32'd7);
        step(1'b0, MD_NONE, '0, '0);
        step(1'b0, MD_NONE, '0, '0);
        step(1'b1, MD_NONE, '0, '0);
        step(1'b0, MD_MFHI, '0, '0);
        op_then_read(MD_MULT, 32'h0001_0000, 32'h0003_0000);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            op = 4'($urandom_range(0, 8));
            if (m_busy() && $urandom_range(0, 7) != 0) op = MD_NONE;
            v1 = $urandom;
            v2 = $urandom;
            case ($urandom_range(0, 9))
                0: v2 = '0;
                1: begin v1 = 32'h8000_0000; v2 = '1; end
                2: v2 = 32'($urandom_range(1, 9));
                3: v1 = 32'($urandom_range(0, 99));
                default: ;
            endcase
            step(($urandom_range(0, 79) == 0), op, v1, v2);
        end
        idle_free();
        step(1'b0, MD_MFHI, '0, '0);
        step(1'b0, MD_MFLO, '0, '0);

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It sits directly downstream of the D→E pipeline register and consumes the E-stage operand pair together with a decoded multiply/divide opcode. It owns the HI/LO registers and runs mult/multu/div/divu as fixed-latency multi-cycle operations. It exports `E_busy`/`E_start` so the hazard unit can stall any multiply/divide-class instruction waiting in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; must be ≥ 1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `E_mdop` input 4: decoded opcode of the instruction currently in E (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO). A bubble or flush from the D→E register arrives as NONE.
- `E_V1` input 32: rs operand after forwarding.
- `E_V2` input 32: rt operand after forwarding.
- `E_HILO` output 32: HI when `E_mdop`=MFHI, LO when MFLO, otherwise 0. Combinational from the current registers.
- `E_start` output 1: combinational. High when `E_mdop` ∈ {MULT, MULTU, DIV, DIVU} and `E_busy`=0.
- `E_busy` output 1: registered; high while an operation is in flight.

## Operation
- State: `hi`, `lo` (32 each), `cnt` (width ≥ clog2(max latency + 1)), `op_q`, `a_q`, `b_q`.
- `E_busy` is (`cnt` ≠ 0).
- **Start.** On an edge where `E_start`=1:
  - `a_q`←`E_V1`, `b_q`←`E_V2`, `op_q`←`E_mdop`.
  - `cnt` loads `MULT_CYCLES` for MULT/MULTU, or `DIV_CYCLES` for DIV/DIVU.
- **Run.** On each edge with `cnt` ≠ 0, `cnt` decrements. On the edge where `cnt`=1, the result is committed:
  - MULT: {hi,lo}←signed(a_q)×signed(b_q), full 64 bits.
  - MULTU: {hi,lo}←unsigned 64-bit product.
  - DIV: lo←quotient truncated toward zero; hi←remainder, with the sign of the dividend.
  - DIVU: unsigned quotient to lo, unsigned remainder to hi.
  - Divide by zero (`b_q`=0): full latency still elapses; hi/lo stay unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- **Moves.**
  - MTHI: hi←`E_V1` at the edge, when not busy.
  - MTLO: lo←`E_V1` at the edge, when not busy.
  - MFHI/MFLO read combinationally and do not depend on busy.
- **Op arriving while busy.** Any non-NONE `E_mdop` while `E_busy`=1 is a hazard-unit protocol violation. The block ignores it: no start, no MT write, `cnt` and the in-flight operands are undisturbed. MF still drives `E_HILO` from the current hi/lo.
- **Reset.**
  - `hi`, `lo`, `cnt` and `op_q` clear to 0; `E_busy`=0.
  - An operation in progress is discarded with no HI/LO commit.
  - Reset has priority over start, MT and commit on the same edge.

## Timing
- Cycle 0: MULT in E, `E_start`=1.
- Cycles 1..`MULT_CYCLES`: `E_busy`=1.
- Commit happens at the end of cycle `MULT_CYCLES`.
- Cycle `MULT_CYCLES`+1: `E_busy`=0, and an MFLO sees the new value.
- DIV follows the same pattern with `DIV_CYCLES`.
- A new start is accepted in the first cycle with `E_busy`=0, which gives back-to-back operations with no dead cycle.
- MTHI/MTLO take effect at the edge that ends their E cycle. An MFHI in the next cycle sees the written value.
- Reset outputs:
  - `E_busy`=0.
  - `E_HILO`=0 for any op, since hi=lo=0.
  - `E_start` follows `E_mdop`.

## Structure
- Shared package holds:
  - the `E_mdop` encoding constants (NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO);
  - default latencies;
  - a helper `is_md_start(op)`, which the decoder and hazard unit also use.
- No sub-module. Arithmetic is computed inline from the latched operands; the operands are held stable so the counter models the latency.

## Test plan
- Reset, then MFLO and MFHI → `E_HILO`=0 and `E_busy`=0. A MULT issued in the same cycle as reset → no commit, `E_busy`=0 the next cycle.
- MULT V1=0xFFFFFFFE (−2), V2=3:
  - `E_busy` high for exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV V1=0xFFFFFFF9 (−7), V2=2 → after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV edge cases:
  - DIVU 7/0 → hi/lo unchanged after 10 busy cycles.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 in cycle 0 → MFHI in cycle 1 returns 0x12345678. An MTLO injected while busy → lo unchanged, `cnt` unaffected.
- Reset asserted in cycle 3 of a DIV → `E_busy`=0 the next cycle, hi=lo=0. A MULT issued immediately after completes normally.
